// File: rtl/md_sequencer.sv
// md_sequencer: iterative multiply/divide unit for the EX stage.
// One shift-add or restoring-divide step per cycle, then a sign fix-up cycle that writes HI/LO.
module md_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int OPERATE    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  md_start,
    input  logic [OPERATE-1:0]    md_function,
    input  logic [DATA_WIDTH-1:0] md_src1,
    input  logic [DATA_WIDTH-1:0] md_src2,
    input  logic                  md_flush,
    output logic                  md_busy,
    output logic                  md_done,
    output logic                  md_div_by_zero,
    output logic [DATA_WIDTH-1:0] md_hi,
    output logic [DATA_WIDTH-1:0] md_lo
);
    localparam int W  = DATA_WIDTH;
    localparam int W2 = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [OPERATE-1:0] FN_MULT  = OPERATE'(8);
    localparam logic [OPERATE-1:0] FN_MULTU = OPERATE'(9);
    localparam logic [OPERATE-1:0] FN_DIV   = OPERATE'(10);
    localparam logic [OPERATE-1:0] FN_DIVU  = OPERATE'(11);

    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
    localparam logic [CW-1:0] ONE_CW    = CW'(1);
    localparam logic [W-1:0]  ONE_W     = W'(1);
    localparam logic [W2-1:0] ONE_2W    = W2'(1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          div_q, div_d;
    logic          dbz_op_q, dbz_op_d;
    logic          neg_lo_q, neg_lo_d;
    logic          neg_hi_q, neg_hi_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [W2-1:0] acc_q, acc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;

    logic          fn_valid, fn_div, fn_signed, div_zero;
    logic          src1_neg, src2_neg;
    logic [W-1:0]  src1_abs, src2_abs;
    logic [W:0]    mul_sum, div_rem, div_diff;
    logic          div_ge;
    logic [W2-1:0] prod_neg;
    logic [W-1:0]  quo_neg, rem_neg;

    always_comb begin
        fn_valid  = (md_function == FN_MULT) || (md_function == FN_MULTU) ||
                    (md_function == FN_DIV)  || (md_function == FN_DIVU);
        fn_div    = (md_function == FN_DIV) || (md_function == FN_DIVU);
        fn_signed = (md_function == FN_MULT) || (md_function == FN_DIV);
        div_zero  = fn_div && (md_src2 == '0);
        // Divide-by-zero keeps the raw dividend so the remainder comes out as src1 untouched.
        src1_neg  = fn_signed && md_src1[W-1] && !div_zero;
        src2_neg  = fn_signed && md_src2[W-1];
        src1_abs  = src1_neg ? (~md_src1 + ONE_W) : md_src1;
        src2_abs  = src2_neg ? (~md_src2 + ONE_W) : md_src2;

        mul_sum   = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_rem   = acc_q[W2-1:W-1];
        div_ge    = div_rem >= {1'b0, opb_q};
        div_diff  = div_rem - {1'b0, opb_q};
        prod_neg  = ~acc_q + ONE_2W;
        quo_neg   = ~acc_q[W-1:0] + ONE_W;
        rem_neg   = ~acc_q[W2-1:W] + ONE_W;

        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        dbz_op_d = dbz_op_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (md_start && fn_valid && !md_flush) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    div_d    = fn_div;
                    dbz_op_d = div_zero;
                    neg_lo_d = src1_neg ^ src2_neg;
                    neg_hi_d = src1_neg;
                    acc_d    = {{W{1'b0}}, src1_abs};
                    opb_d    = src2_abs;
                end
            end
            CALC: begin
                if (md_flush) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ONE_CW;
                    if (div_q) begin
                        acc_d = {(div_ge ? div_diff[W-1:0] : div_rem[W-1:0]), acc_q[W-2:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[W-1:1]};
                    end
                    if (cnt_q == LAST_ITER) begin
                        state_d = SIGN;
                    end
                end
            end
            SIGN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!md_flush) begin
                    done_d = 1'b1;
                    dbz_d  = dbz_op_q;
                    if (div_q) begin
                        hi_d = neg_hi_q ? rem_neg : acc_q[W2-1:W];
                        lo_d = neg_lo_q ? quo_neg : acc_q[W-1:0];
                    end else begin
                        {hi_d, lo_d} = neg_lo_q ? prod_neg : acc_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            dbz_op_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            dbz_op_q <= dbz_op_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign md_busy        = busy_q;
    assign md_done        = done_q;
    assign md_div_by_zero = dbz_q;
    assign md_hi          = hi_q;
    assign md_lo          = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed vector table, corner-case sequences and random ops
// checked against a 64-bit arithmetic reference model.
module tb_md_sequencer;
    localparam logic [4:0] FN_MULT  = 5'b01000;
    localparam logic [4:0] FN_MULTU = 5'b01001;
    localparam logic [4:0] FN_DIV   = 5'b01010;
    localparam logic [4:0] FN_DIVU  = 5'b01011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        md_start = 1'b0;
    logic        md_flush = 1'b0;
    logic [4:0]  md_function = '0;
    logic [31:0] md_src1 = '0;
    logic [31:0] md_src2 = '0;
    logic        md_busy, md_done, md_div_by_zero;
    logic [31:0] md_hi, md_lo;

    int errors = 0;
    int checks = 0;

    md_sequencer #(.DATA_WIDTH(32), .OPERATE(5)) dut (
        .clk(clk), .rst_n(rst_n), .md_start(md_start), .md_function(md_function),
        .md_src1(md_src1), .md_src2(md_src2), .md_flush(md_flush),
        .md_busy(md_busy), .md_done(md_done), .md_div_by_zero(md_div_by_zero),
        .md_hi(md_hi), .md_lo(md_lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [4:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo} straight from the arithmetic definition of each op.
    function automatic logic [64:0] model(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a) & 64'h0000_0000_FFFF_FFFF;
        ub = longint'(b) & 64'h0000_0000_FFFF_FFFF;
        case (fn)
            FN_MULT:  begin p = sa * sb; return {1'b0, p}; end
            FN_MULTU: begin p = ua * ub; return {1'b0, p}; end
            FN_DIV: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                q = sq;
                r = sr;
                return {1'b0, r[31:0], q[31:0]};
            end
            FN_DIVU: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                q = ua / ub;
                r = ua % ub;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: return '0;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"}, md_busy, 0);
        check({tag, " done"}, md_done, 0);
        check({tag, " dbz"}, md_div_by_zero, 0);
        check({tag, " hi"}, md_hi, 0);
        check({tag, " lo"}, md_lo, 0);
    endtask

    // Presents a request for one edge; operands are scrambled afterwards so they must have been latched.
    task automatic issue(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b);
        md_start    = 1'b1;
        md_function = fn;
        md_src1     = a;
        md_src2     = b;
        @(posedge clk);
        @(negedge clk);
        md_start = 1'b0;
        md_src1  = $urandom;
        md_src2  = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz,
                          input int poke_k);
        int          k;
        int          busy_cnt;
        bit          bad;
        logic [31:0] hi0, lo0;
        hi0 = md_hi;
        lo0 = md_lo;
        issue(fn, a, b);
        k = 0;
        busy_cnt = 0;
        bad = 1'b0;
        while (md_done !== 1'b1 && k < 80) begin
            if (md_busy === 1'b1) busy_cnt++;
            if (md_div_by_zero !== 1'b0 || md_hi !== hi0 || md_lo !== lo0) bad = 1'b1;
            md_start = (k == poke_k);
            if (k == poke_k) begin
                md_function = FN_MULTU;
                md_src1 = $urandom;
                md_src2 = $urandom;
            end
            @(negedge clk);
            k++;
        end
        md_start = 1'b0;
        check({tag, " latency"}, k, 33);
        check({tag, " busy_cycles"}, busy_cnt, 33);
        check({tag, " busy_in_done"}, md_busy, 0);
        check({tag, " quiet_while_busy"}, bad, 0);
        check({tag, " hi"}, md_hi, exp_hi);
        check({tag, " lo"}, md_lo, exp_lo);
        check({tag, " dbz"}, md_div_by_zero, exp_dbz);
    endtask

    task automatic watch_quiet(input string tag, input int cycles, input logic [31:0] hi0, input logic [31:0] lo0);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (md_done !== 1'b0 || md_busy !== 1'b0 || md_div_by_zero !== 1'b0 ||
                md_hi !== hi0 || md_lo !== lo0) bad = 1'b1;
            @(negedge clk);
        end
        check({tag, " quiet"}, bad, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        vec_t        vecs[11];
        logic [64:0] m;
        logic [31:0] hi0, lo0, a, b;
        logic [4:0]  fn;
        logic [4:0]  bad_fn[2];

        vecs[0]  = '{FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{FN_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2]  = '{FN_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{FN_MULT,  32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
        vecs[4]  = '{FN_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{FN_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[6]  = '{FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[7]  = '{FN_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{FN_DIV,   32'hFFFF_FFF7, 32'h0000_0000, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{FN_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[10] = '{FN_DIV,   32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0};
        bad_fn[0] = 5'b01100;
        bad_fn[1] = 5'b11000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_zero("reset");

        // Each op is issued in the done cycle of the previous one, so these run back-to-back.
        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz, -1);
        end
        @(negedge clk);
        check("done_one_cycle", md_done, 0);
        check("dbz_after_done", md_div_by_zero, 0);
        check("hold_hi", md_hi, 32'h0);
        check("hold_lo", md_lo, 32'h0);

        run_op("start_while_busy", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 4);
        @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            md_start = 1'b1;
            md_function = bad_fn[i];
            md_src1 = 32'h1234_5678;
            md_src2 = 32'h9;
            @(posedge clk);
            @(negedge clk);
            md_start = 1'b0;
            watch_quiet($sformatf("bad_fn%0d", i), 40, 32'd2, 32'd14);
        end

        md_start = 1'b1;
        md_flush = 1'b1;
        md_function = FN_DIVU;
        @(posedge clk);
        @(negedge clk);
        md_start = 1'b0;
        md_flush = 1'b0;
        watch_quiet("flush_beats_start", 40, 32'd2, 32'd14);

        issue(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        md_flush = 1'b1;
        @(negedge clk);
        md_flush = 1'b0;
        watch_quiet("flush_calc", 40, 32'd2, 32'd14);

        issue(FN_MULT, 32'hFFFF_FFFD, 32'h5);
        repeat (32) @(negedge clk);
        md_flush = 1'b1;
        @(negedge clk);
        md_flush = 1'b0;
        watch_quiet("flush_sign", 40, 32'd2, 32'd14);

        for (int i = 0; i < 40; i++) begin
            fn = FN_MULT + 5'($urandom_range(0, 3));
            a = pick_operand();
            b = pick_operand();
            m = model(fn, a, b);
            run_op($sformatf("rnd%0d fn=%0h a=%0h b=%0h", i, fn, a, b), fn, a, b,
                   m[63:32], m[31:0], m[64], -1);
        end

        run_op("pre_reset", FN_MULT, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, -1);
        issue(FN_DIV, 32'hFFFF_FFF9, 32'h2);
        repeat (19) @(negedge clk);
        do_reset();
        check_zero("reset_mid_op");
        hi0 = 32'h0;
        lo0 = 32'h0;
        watch_quiet("after_reset", 40, hi0, lo0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
